// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared FSM state type and default constants for mux_arbiter.
package mux_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_e;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mux_arbiter_mux2_bus.sv
// mux2_bus: WIDTH-bit 2:1 selector, sel=0 gives a, sel=1 gives b.
module mux2_bus #(
  parameter int WIDTH = 4
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester arbiter with minimum hold and registered data mux.
// Define MUX_ARBITER_TIMEOUT_EN to let a waiting requester preempt a long grant.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               CLOCK_50,
  input  logic               RST,
  input  logic [1:0]         REQ,
  input  logic [2*WIDTH-1:0] SW,
  output logic [1:0]         GNT,
  output logic [WIDTH-1:0]   LEDR
);
  localparam int CW = $clog2(max2(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  state_e state_q, state_d, other;
  logic last_b_q, last_b_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] ledr_q, ledr_d, mux_y;
  logic hold_done, own_req, oth_req, entry;
`ifdef MUX_ARBITER_TIMEOUT_EN
  logic [CW-1:0] to_q, to_d;
  logic to_done;
`endif
  assign own_req = state_q == GRANT_B ? REQ[1] : REQ[0];
  assign oth_req = state_q == GRANT_B ? REQ[0] : REQ[1];
  assign other = state_q == GRANT_A ? GRANT_B : GRANT_A;
  // "done" means the count reaches the limit at the end of the current cycle
  assign hold_done = hold_q >= CW'(HOLD_CYCLES - 1);
`ifdef MUX_ARBITER_TIMEOUT_EN
  assign to_done = to_q >= CW'(TIMEOUT_CYCLES - 1);
`endif
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = REQ == 2'b11 ? (last_b_q ? GRANT_A : GRANT_B) :
                REQ == 2'b01 ? GRANT_A : REQ == 2'b10 ? GRANT_B : IDLE;
    else if (hold_done && !own_req)
      state_d = oth_req ? other : IDLE;
`ifdef MUX_ARBITER_TIMEOUT_EN
    else if (hold_done && to_done && oth_req)
      state_d = other;
`endif
    entry = state_d != IDLE && state_d != state_q;
    last_b_d = entry ? state_d == GRANT_B : last_b_q;
    hold_d = (entry || state_d == IDLE) ? '0 :
             hold_q == CW'(HOLD_CYCLES) ? hold_q : hold_q + CW'(1);
`ifdef MUX_ARBITER_TIMEOUT_EN
    to_d = (entry || state_d == IDLE) ? '0 :
           to_q == CW'(TIMEOUT_CYCLES) ? to_q : to_q + CW'(1);
`endif
  end
  mux2_bus #(.WIDTH(WIDTH)) u_mux (
    .sel(state_d == GRANT_B),
    .a  (SW[WIDTH-1:0]),
    .b  (SW[2*WIDTH-1:WIDTH]),
    .y  (mux_y)
  );
  assign ledr_d = state_d == IDLE ? '0 : mux_y;
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      hold_q   <= '0;
      ledr_q   <= '0;
`ifdef MUX_ARBITER_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      hold_q   <= hold_d;
      ledr_q   <= ledr_d;
`ifdef MUX_ARBITER_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end
  assign GNT  = {state_q == GRANT_B, state_q == GRANT_A};
  assign LEDR = ledr_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios plus random traffic checked against a cycle model.
module tb_mux_arbiter;
  localparam int W = 4, H = 8, T = 64;
  typedef logic [2*W-1:0] sw_t;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0;
  sw_t sw = 0;
  logic [1:0] gnt;
  logic [W-1:0] ledr;
  int pass = 0, total = 0;
  int own = 0, n = 0, last = 2;
  logic [W-1:0] m_led = 0;
  bit on = 0, fin = 0;
  always #5 clk = ~clk;
  mux_arbiter #(.WIDTH(W), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50(clk), .RST(rst), .REQ(req), .SW(sw), .GNT(gnt), .LEDR(ledr)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    else pass++;
  endtask
  // owner: 0 none, 1 A, 2 B; n counts granted cycles completed in the current grant
  always @(posedge clk) begin : model
    int nxt, n1, oth;
    if (rst) begin
      own = 0; n = 0; last = 2; m_led = '0; on = 1;
    end else begin
      nxt = own; n1 = n + 1; oth = 3 - own;
      if (own == 0) nxt = req == 2'b11 ? 3 - last : req == 2'b01 ? 1 : req == 2'b10 ? 2 : 0;
      else if (n1 >= H) begin
        if (!req[own-1]) nxt = req[oth-1] ? oth : 0;
`ifdef MUX_ARBITER_TIMEOUT_EN
        else if (n1 >= T && req[oth-1]) nxt = oth;
`endif
      end
      n = nxt != own ? 0 : n1;
      if (nxt != own && nxt != 0) last = nxt;
      m_led = nxt == 1 ? sw[W-1:0] : nxt == 2 ? sw[2*W-1:W] : '0;
      own = nxt;
    end
  end
  always @(negedge clk) if (on && !fin) begin
    check("gnt", {30'd0, gnt}, own == 1 ? 32'd1 : own == 2 ? 32'd2 : 32'd0);
    check("ledr", {28'd0, ledr}, {28'd0, m_led});
  end
  task automatic tick(input logic r, input logic [1:0] q, input sw_t s);
    rst = r; req = q; sw = s;
    @(posedge clk); #1;
  endtask
  initial begin
    int cnt;
    bit run;
    sw_t s;
    logic r;
    logic [1:0] q;
    tick(1, 2'b00, '0);
    check("reset_gnt", {30'd0, gnt}, 32'd0);
    check("reset_ledr", {28'd0, ledr}, 32'd0);
    tick(0, 2'b01, 8'h0A);
    check("a_grant", {30'd0, gnt}, 32'd1);
    check("a_ledr", {28'd0, ledr}, 32'hA);
    tick(0, 2'b01, 8'h0A);
    cnt = 2;
    for (int i = 0; i < 20 && gnt == 2'b01; i++) begin
      tick(0, 2'b00, 8'h0A);
      if (gnt == 2'b01) cnt++;
    end
    check("hold_len", cnt, H);
    check("idle_gnt", {30'd0, gnt}, 32'd0);
    check("idle_ledr", {28'd0, ledr}, 32'd0);
    tick(1, 2'b00, '0);
    tick(0, 2'b11, 8'h53);
    check("both_a_first", {30'd0, gnt}, 32'd1);
    for (int i = 1; i < H; i++) tick(0, 2'b11, 8'h53);
    check("a_still", {30'd0, gnt}, 32'd1);
    tick(0, 2'b10, 8'h53);
    check("direct_b", {30'd0, gnt}, 32'd2);
    check("b_ledr", {28'd0, ledr}, 32'h5);
    tick(1, 2'b00, '0);
    cnt = 0; run = 1;
    for (int i = 0; i < 200; i++) begin
      tick(0, i < 4 ? 2'b01 : 2'b11, 8'h21);
      if (run && gnt == 2'b01) cnt++;
      else run = 0;
    end
`ifdef MUX_ARBITER_TIMEOUT_EN
    check("timeout_run", cnt, T);
`else
    check("no_timeout_run", cnt, 200);
`endif
    tick(1, 2'b00, '0);
    for (int i = 0; i < 4; i++) tick(0, 2'b10, 8'h70);
    check("b_mid_hold", {30'd0, gnt}, 32'd2);
    tick(1, 2'b11, 8'h69);
    check("rst_mid_gnt", {30'd0, gnt}, 32'd0);
    check("rst_mid_ledr", {28'd0, ledr}, 32'd0);
    tick(0, 2'b11, 8'h69);
    check("post_rst_a", {30'd0, gnt}, 32'd1);
    check("post_rst_ledr", {28'd0, ledr}, 32'h9);
    tick(1, 2'b00, '0);
    tick(0, 2'b01, '0);
    for (int i = 0; i < 20; i++) begin
      s = sw_t'($urandom);
      tick(0, 2'b01, s);
      check("led_track", {28'd0, ledr}, {28'd0, s[W-1:0]});
    end
    q = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) q = 2'($urandom);
      r = $urandom_range(0, 80) == 0;
      tick(r, q, sw_t'($urandom));
    end
    fin = 1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each requester bus and of LEDR.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, minimum number of cycles a grant is held.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum grant length while the other requester waits (used only with the timeout feature).
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port REQ, input, 2 bits: REQ[0] is the request from requester A and REQ[1] from requester B.
REQ-007 SHALL have port SW, input, 2*WIDTH bits: SW[0:WIDTH-1] is A's data and SW[WIDTH:2*WIDTH-1] is B's data.
REQ-008 SHALL have port GNT, output, 2 bits: one-hot grant, or 00 when idle.
REQ-009 SHALL have port LEDR, output, WIDTH bits: registered data of the granted requester.

Function
REQ-010 SHALL implement an FSM with states IDLE, GRANT_A and GRANT_B, where GNT=01 in GRANT_A, GNT=10 in GRANT_B and GNT=00 in IDLE.
REQ-011 SHALL, in IDLE, go to GRANT_A if only A requests, go to GRANT_B if only B requests, and otherwise stay in IDLE.
REQ-012 SHALL, in IDLE when both request, grant the requester that was NOT served last; the last-served pointer resets to B so that A wins first.
REQ-013 SHALL register GNT, so a request asserted at cycle n produces a grant at the edge ending cycle n.
REQ-014 SHALL clear the hold counter on grant entry; the counter increments each granted cycle and saturates at HOLD_CYCLES.
REQ-015 SHALL keep the grant regardless of REQ until the hold counter reaches HOLD_CYCLES.
REQ-016 SHALL handle the end of hold, when the owner's request is low, as follows: switch directly to the other grant if the other requester is high, otherwise go to IDLE.
REQ-017 SHALL, after hold with the owner's request still high and the timeout feature off, keep the grant indefinitely.
REQ-018 SHALL update the last-served pointer on every grant entry.
REQ-019 SHALL register LEDR, loading on the same edge as GNT with the data of the next-state grantee, or all zeros when the next state is IDLE.
REQ-020 SHALL, while a grant is held, have LEDR track the grantee's SW data with 1-cycle latency.
REQ-021 SHALL size the counters as $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1) bits, and they SHALL never wrap.

Reset
REQ-022 SHALL, when RST is high at an edge, set the state to IDLE, GNT=00, LEDR=0, both counters to 0 and the last-served pointer to B.
REQ-023 SHALL give reset priority over all other events, including mid-grant and mid-hold.
REQ-024 SHALL, on the first edge after RST is released, evaluate REQ normally.

Configuration
REQ-025 SHALL use macro MUX_ARBITER_TIMEOUT_EN to compile the timeout feature in or out.
REQ-026 SHALL, with MUX_ARBITER_TIMEOUT_EN defined, count granted cycles; when the count reaches TIMEOUT_CYCLES and the other requester is high, the grant switches to the other requester even if the owner is still requesting.
REQ-027 SHALL, with MUX_ARBITER_TIMEOUT_EN undefined, contain no timeout counter logic, and behaviour follows REQ-017.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, GRANT_A, GRANT_B) and the default constants in shared package mux_arbiter_pkg.
REQ-029 SHALL instantiate sub-module mux2_bus, a parameterised WIDTH-bit 2:1 selector (select 0 gives A, 1 gives B) that drives the LEDR register input.

Verification
REQ-030 SHALL cover: reset, then REQ=01, SW A=1010 -> next edge GNT=01, LEDR=1010; drop REQ at cycle 2 -> GNT stays 01 until 8 granted cycles have elapsed, then IDLE and LEDR=0.
REQ-031 SHALL cover: REQ=11 from reset -> GNT=01 first; A drops after hold -> GNT=10 on the next edge with no IDLE cycle, and LEDR shows B's data.
REQ-032 SHALL cover: A requests continuously and B requests at cycle 5 -> without the macro GNT stays 01 for 200 cycles; with MUX_ARBITER_TIMEOUT_EN, GNT=10 after 64 granted cycles.
REQ-033 SHALL cover: RST asserted mid-GRANT_B at hold count 3 -> next edge GNT=00, LEDR=0; with REQ=11 held, the first post-reset grant is A.
REQ-034 SHALL cover: SW A changing every cycle during a grant -> LEDR equals A's data delayed by 1 cycle; SW B changes have no effect.
